// File: rtl/led_matrix_scanner_if.sv
// rtl/led_matrix_scanner_if.sv - pin bundle between the scanner and the LED matrix board
//
// Signals:
//   ser_data   serial colour bit, sampled by the board on ser_clk rising edge
//   ser_clk    shift clock for the board's column shift registers
//   ser_latch  one-cycle pulse moving the shift registers onto the column drivers
//   row_sel    index of the row being driven
//   row_en     row driver enable, active high
// Modports: master = scanner (drives the pins), slave = board side (observes them).
interface led_matrix_scanner_if;
    logic       ser_data;
    logic       ser_clk;
    logic       ser_latch;
    logic [3:0] row_sel;
    logic       row_en;

    modport master (output ser_data, ser_clk, ser_latch, row_sel, row_en);
    modport slave  (input  ser_data, ser_clk, ser_latch, row_sel, row_en);
endinterface

// File: rtl/led_matrix_scanner.sv
// rtl/led_matrix_scanner.sv - 16x16 red/green frame snapshot and row-serial LED matrix scan-out
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   enable       scan enable, sampled in IDLE and on the last dwell cycle of a row
//   RedPixels    red plane, bit c of RedPixels[r] is row r column c
//   GrnPixels    green plane, same mapping
//   board        master side of the board pin bundle (ser_data/ser_clk/ser_latch/row_sel/row_en)
//   frame_start  one-cycle pulse in the LOAD cycle of each row-0 snapshot
// Parameters:
//   SCLK_DIV      clk cycles per ser_clk half-period (>=1)
//   DWELL_CYCLES  clk cycles a row stays lit (>=1)
module led_matrix_scanner #(
    parameter int SCLK_DIV     = 2,
    parameter int DWELL_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [15:0][15:0]    RedPixels,
    input  logic [15:0][15:0]    GrnPixels,
    led_matrix_scanner_if.master board,
    output logic                 frame_start
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_DWELL = 3'd4;

    localparam int DIV_W   = $clog2(2 * SCLK_DIV + 1);
    localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [DIV_W-1:0]   HALF       = DIV_W'(SCLK_DIV);
    localparam logic [DIV_W-1:0]   PH_LAST    = DIV_W'(2 * SCLK_DIV - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    logic [2:0]         state;
    logic [3:0]         row;
    logic [4:0]         bit_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   div_next;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [30:0]        shift_word;   // bits still to send after the one on ser_data
    logic [31:0]        load_word;
    logic [15:0][15:0]  red_buf;
    logic [15:0][15:0]  grn_buf;
    logic               dwell_done;
    logic               snap;

    // div_cnt walks one bit period: [0, SCLK_DIV) is the low phase, the rest is high.
    assign div_next   = (div_cnt == PH_LAST) ? '0 : div_cnt + 1'b1;
    assign dwell_done = (state == S_DWELL) && (dwell_cnt == DWELL_LAST);
    assign load_word  = {grn_buf[row], red_buf[row]};

    // Snapshot on the edge that enters a row-0 LOAD, so the LOAD cycle already
    // reads the fresh frame and later input changes cannot tear it.
    assign snap = enable && ((state == S_IDLE) || (dwell_done && (row == 4'd15)));

    always_ff @(posedge clk) begin
        if (snap) begin
            red_buf <= RedPixels;
            grn_buf <= GrnPixels;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            row             <= '0;
            bit_cnt         <= '0;
            div_cnt         <= '0;
            dwell_cnt       <= '0;
            shift_word      <= '0;
            board.ser_data  <= 1'b0;
            board.ser_clk   <= 1'b0;
            board.ser_latch <= 1'b0;
            board.row_sel   <= '0;
            board.row_en    <= 1'b0;
            frame_start     <= 1'b0;
        end else begin
            frame_start     <= snap;
            board.ser_latch <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) state <= S_LOAD;
                end
                S_LOAD: begin
                    board.ser_data <= load_word[31];
                    board.ser_clk  <= 1'b0;
                    shift_word     <= load_word[30:0];
                    bit_cnt        <= '0;
                    div_cnt        <= '0;
                    state          <= S_SHIFT;
                end
                S_SHIFT: begin
                    div_cnt       <= div_next;
                    board.ser_clk <= (div_next >= HALF);
                    if (div_cnt == PH_LAST) begin
                        if (bit_cnt == 5'd31) begin
                            board.ser_data  <= 1'b0;
                            board.ser_latch <= 1'b1;
                            board.row_sel   <= row;
                            state           <= S_LATCH;
                        end else begin
                            // new bit goes out together with ser_clk falling
                            board.ser_data <= shift_word[30];
                            shift_word     <= {shift_word[29:0], 1'b0};
                            bit_cnt        <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_LATCH: begin
                    board.row_en <= 1'b1;
                    dwell_cnt    <= '0;
                    state        <= S_DWELL;
                end
                S_DWELL: begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                    if (dwell_done) begin
                        board.row_en <= 1'b0;
                        if (enable) begin
                            row   <= row + 1'b1;
                            state <= S_LOAD;
                        end else begin
                            row           <= '0;
                            board.row_sel <= '0;
                            state         <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb/tb_led_matrix_scanner.sv - scoreboard bench for led_matrix_scanner (default and minimum parameters)
module tb_led_matrix_scanner;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n, enable, reset_b, enable_b;
    logic [15:0][15:0] red, grn, red_b, grn_b;
    logic              frame_start, frame_start_b;

    led_matrix_scanner_if bus_a();
    led_matrix_scanner_if bus_b();

    led_matrix_scanner dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .RedPixels(red), .GrnPixels(grn), .board(bus_a), .frame_start(frame_start)
    );

    led_matrix_scanner #(.SCLK_DIV(1), .DWELL_CYCLES(1)) dut_b (
        .clk(clk), .reset_n(reset_b), .enable(enable_b),
        .RedPixels(red_b), .GrnPixels(grn_b), .board(bus_b), .frame_start(frame_start_b)
    );

    typedef struct {
        logic [31:0] word;
        logic [3:0]  row;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   done_b = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic [3:0] r);
        exp_t e;
        e.word = w;
        e.row  = r;
        exp_q.push_back(e);
    endtask

    function automatic logic [8:0] outs_a();
        return {bus_a.ser_data, bus_a.ser_clk, bus_a.ser_latch, bus_a.row_sel, bus_a.row_en, frame_start};
    endfunction

    function automatic bit cond(input int kind, input logic [3:0] r);
        case (kind)
            0:       return frame_start === 1'b1;
            1:       return (bus_a.row_en === 1'b1) && (bus_a.row_sel === r);
            2:       return bus_a.row_en === 1'b0;
            default: return bus_a.ser_clk === 1'b1;
        endcase
    endfunction

    task automatic wait_for(input int kind, input logic [3:0] r, input int limit, input string name);
        int n = 0;
        while (!cond(kind, r) && n < limit) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!cond(kind, r)) begin
            fails++;
            $display("FAIL %s: condition not reached within %0d cycles", name, limit);
        end
    endtask

    // ---------------- monitor for dut_a ----------------
    logic [31:0] cap;
    int          nbits, dwell_len;
    logic        pclk, plat, pen, pdata, row_stable;
    logic [3:0]  exp_row, en_row;
    exp_t        got_e;

    always @(negedge clk) begin
        if (!reset_n) begin
            nbits = 0; cap = '0; pclk = 1'b0; plat = 1'b0; pen = 1'b0; pdata = 1'b0; dwell_len = 0;
        end else begin
            if (bus_a.ser_clk && pclk) check("data_stable_while_sclk_high", bus_a.ser_data, pdata);
            if (bus_a.ser_clk && !pclk) begin
                cap = {cap[30:0], bus_a.ser_data};
                nbits++;
            end
            if (bus_a.ser_latch) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_row: word %08h latched with empty scoreboard", cap);
                end else begin
                    got_e = exp_q.pop_front();
                    check("row_word", cap, got_e.word);
                    check("bits_per_row", nbits, 32);
                    exp_row = got_e.row;
                end
                nbits = 0;
            end
            if (bus_a.row_en && !pen) begin
                check("latch_falls_as_row_en_rises", {plat, bus_a.ser_latch}, 2'b10);
                check("row_sel", bus_a.row_sel, exp_row);
                en_row = bus_a.row_sel; row_stable = 1'b1; dwell_len = 0;
            end
            if (bus_a.row_en) begin
                dwell_len++;
                if (bus_a.row_sel !== en_row) row_stable = 1'b0;
            end
            if (!bus_a.row_en && pen) begin
                check("dwell_length", dwell_len, 1024);
                check("row_sel_stable_in_dwell", row_stable, 1'b1);
            end
            pclk = bus_a.ser_clk; plat = bus_a.ser_latch; pen = bus_a.row_en; pdata = bus_a.ser_data;
        end
    end

    // ---------------- monitor for dut_b (SCLK_DIV=1, DWELL_CYCLES=1) ----------------
    logic [31:0] cap_b;
    int          nb_b, last_rise_b, last_en_b;
    logic        pclk_b, pen_b, have_en_b;
    logic [3:0]  brow = 4'd0;

    always @(negedge clk) begin
        if (!reset_b) begin
            nb_b = 0; cap_b = '0; pclk_b = 1'b0; pen_b = 1'b0; have_en_b = 1'b0;
        end else begin
            if (bus_b.ser_clk) check("b_sclk_high_one_cycle", pclk_b, 1'b0);
            if (bus_b.ser_clk && !pclk_b) begin
                if (nb_b > 0) check("b_sclk_period", cyc - last_rise_b, 2);
                last_rise_b = cyc;
                cap_b = {cap_b[30:0], bus_b.ser_data};
                nb_b++;
            end
            if (bus_b.ser_latch) begin
                check("b_row_word", cap_b, 32'hC3A5_1234);
                check("b_bits_per_row", nb_b, 32);
                nb_b = 0;
            end
            if (bus_b.row_en) check("b_row_en_one_cycle", pen_b, 1'b0);
            if (bus_b.row_en && !pen_b) begin
                if (have_en_b) check("b_row_period", cyc - last_en_b, 67);
                check("b_row_sel", bus_b.row_sel, brow);
                brow = brow + 4'd1;
                last_en_b = cyc; have_en_b = 1'b1;
            end
            pclk_b = bus_b.ser_clk; pen_b = bus_b.row_en;
        end
    end

    // ---------------- stimulus for dut_b ----------------
    initial begin
        reset_b = 1'b0; enable_b = 1'b0;
        for (int r = 0; r < 16; r++) begin
            red_b[r] = 16'h1234;
            grn_b[r] = 16'hC3A5;
        end
        repeat (4) @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        enable_b = 1'b1;
        @(negedge clk);
        check("b_frame_start", frame_start_b, 1'b1);
        repeat (67 * 20) @(negedge clk);
        enable_b = 1'b0;
        repeat (100) @(negedge clk);
        check("b_idle_outputs",
              {bus_b.ser_data, bus_b.ser_clk, bus_b.ser_latch, bus_b.row_sel, bus_b.row_en, frame_start_b}, 9'd0);
        done_b = 1'b1;
    end

    // ---------------- stimulus for dut_a ----------------
    int t0;
    initial begin
        reset_n = 1'b0; enable = 1'b0; red = '0; grn = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs_a(), 9'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_outputs", outs_a(), 9'd0);

        // frame 1: single-row pattern
        red[0] = 16'h8001; grn[0] = 16'h00F0;
        push(32'h00F0_8001, 4'd0);
        for (int r = 1; r < 16; r++) push(32'h0, 4'(r));
        enable = 1'b1;
        @(negedge clk);
        check("enable_to_frame_start", frame_start, 1'b1);
        check("first_row_sel", bus_a.row_sel, 4'd0);
        t0 = cyc;

        // frame 2: diagonal pattern, applied after frame 1's snapshot
        for (int r = 0; r < 16; r++) begin
            red[r] = 16'h1 << r;
            grn[r] = 16'h1 << r;
            push(((32'h1 << r) << 16) | (32'h1 << r), 4'(r));
        end
        @(negedge clk);
        check("frame_start_one_cycle", frame_start, 1'b0);
        wait_for(0, 4'd0, 20000, "frame2_start");
        check("frame_period_1", cyc - t0, 18464);
        t0 = cyc;

        // change row 5 while frame 2 is on row 2: frame 2 keeps the old value
        wait_for(1, 4'd2, 5000, "frame2_row2");
        red[5] = 16'hFFFF;
        for (int r = 0; r < 8; r++)
            push((r == 5) ? 32'h0020_FFFF : (((32'h1 << r) << 16) | (32'h1 << r)), 4'(r));
        @(negedge clk);
        wait_for(0, 4'd0, 20000, "frame3_start");
        check("frame_period_2", cyc - t0, 18464);

        // drop enable during row 7 shift
        wait_for(1, 4'd6, 10000, "frame3_row6");
        wait_for(2, 4'd0, 2000, "frame3_row6_end");
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_for(1, 4'd7, 3000, "row7_dwell");
        wait_for(2, 4'd0, 2000, "row7_end");
        check("idle_after_drop", outs_a(), 9'd0);
        repeat (20) @(negedge clk);
        check("idle_hold", outs_a(), 9'd0);
        check("rows_after_drop", exp_q.size(), 0);

        // re-enable restarts at row 0
        push(32'h0001_0001, 4'd0);
        enable = 1'b1;
        @(negedge clk);
        check("reenable_frame_start", frame_start, 1'b1);
        check("reenable_row_sel", bus_a.row_sel, 4'd0);

        // asynchronous reset in the middle of SHIFT
        repeat (20) @(negedge clk);
        wait_for(3, 4'd0, 8, "sclk_high_before_reset");
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", outs_a(), 9'd0);
        exp_q.delete();
        push(32'h0001_0001, 4'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_frame_start", frame_start, 1'b1);
        check("post_reset_row_sel", bus_a.row_sel, 4'd0);
        enable = 1'b0;
        wait_for(1, 4'd0, 2000, "post_reset_row0");
        wait_for(2, 4'd0, 2000, "post_reset_row0_end");
        check("final_idle", outs_a(), 9'd0);

        wait (done_b == 1'b1 || cyc > 90000);
        check("b_done", done_b, 1'b1);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 95000 cycles");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Consumer end of the 16x16 red/green pixel-array interface that every screen generator in the design drives. It snapshots the two pixel arrays at each frame start and scans the frame out one row at a time to the LED matrix board. Each row's 32 colour bits are shifted serially into the board's shift registers, the shift registers are latched, and the row driver is then enabled for a fixed dwell time. The block sits between the screen/game-state muxing logic and the GPIO pins of the matrix board.

## Interface
Parameters:
- SCLK_DIV, default 2: clk cycles per ser_clk half-period (≥1).
- DWELL_CYCLES, default 1024: clk cycles a row stays lit (≥1).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  scan enable, sampled only in IDLE and on the last DWELL cycle.
- RedPixels  input  [15:0][15:0]  red plane; bit c of RedPixels[r] is row r, column c.
- GrnPixels  input  [15:0][15:0]  green plane, same mapping as RedPixels.
- ser_data  output  1  serial colour bit to the board.
- ser_clk  output  1  shift clock; the board samples ser_data on its rising edge.
- ser_latch  output  1  one-cycle pulse that transfers the shift registers to the column drivers.
- row_sel  output  4  index of the row being driven.
- row_en  output  1  row driver enable, active high.
- frame_start  output  1  one-cycle pulse when a new frame snapshot is taken.

## Operation
- States: IDLE, LOAD, SHIFT, LATCH, DWELL. Internal registers: row counter (4 b), bit counter (5 b), divider counter, dwell counter, and a 512-bit frame buffer.
- IDLE: all outputs 0 and row counter = 0. If enable=1, go to LOAD on the next cycle.
- LOAD (1 cycle):
  - If row==0, copy RedPixels and GrnPixels into the frame buffer and pulse frame_start.
  - Load a 32-bit shift word from the buffer: {Grn[row][15:0], Red[row][15:0]}.
  - Go to SHIFT.
- SHIFT: emit the 32 bits MSB first, so Grn bit 15 goes first and Red bit 0 goes last.
  - Each bit holds ser_data for 2*SCLK_DIV cycles.
  - ser_clk is low for the first SCLK_DIV cycles and high for the last SCLK_DIV cycles.
  - ser_data changes only while ser_clk is low.
  - After bit 31's high phase, go to LATCH with ser_clk=0.
- LATCH (1 cycle): ser_latch=1, and row_sel updates to the current row. Go to DWELL.
- DWELL: row_en=1 for exactly DWELL_CYCLES cycles. On the last cycle:
  - Row counter increments, wrapping 15→0.
  - If enable=1, go to LOAD; otherwise go to IDLE, which resets the row counter to 0.
- row_en=0 in every state except DWELL (blanking during shift, to prevent ghosting).
- Input changes after a snapshot are invisible until the next row-0 LOAD, so frames never tear.
- Deasserting enable mid-row has no effect until the row's DWELL completes.
- Asserting reset_n=0 at any point forces IDLE immediately, with all outputs 0. The frame buffer contents are don't-care.

## Timing
- Reset values: ser_data=0, ser_clk=0, ser_latch=0, row_sel=0, row_en=0, frame_start=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: enable rises at cycle 0 → LOAD at cycle 1, with frame_start=1 in that same cycle. The first ser_clk rise comes SCLK_DIV cycles after SHIFT entry.
- Cycles per row = 1 + 64*SCLK_DIV + 1 + DWELL_CYCLES. Defaults give 1154 per row and 18464 per frame.
- frame_start pulses are exactly 16 rows apart while enable stays high.
- ser_latch falls the same cycle row_en rises.
- row_sel is stable for the full DWELL period.

## Test plan
- Reset mid-SHIFT: assert reset_n=0 → all outputs 0 within the same cycle (asynchronous). After release with enable=1, frame_start comes 1 cycle later and row_sel=0.
- Pattern check: RedPixels[0]=16'h8001, GrnPixels[0]=16'h00F0, all other rows 0. Sample ser_data on ser_clk rises → first word 32'h00F0_8001, ser_latch, then row_sel=0 with row_en high for 1024 cycles.
- Full frame: set each row r so that Red[r]=Grn[r]=1<<r → 16 words captured in row order 0..15. The word for row r is ((1<<r)<<16)|(1<<r). row_sel wraps 15→0 and frame_start pulses at an 18464-cycle period.
- Snapshot isolation: change RedPixels[5] to 16'hFFFF during row 2 → row 5 of the current frame still shows the old value; the next frame shows 16'hFFFF.
- Enable drop: deassert enable during row 7 SHIFT → row 7 completes its full dwell, then the block goes IDLE with all outputs 0. Re-enabling restarts at row 0 with a frame_start pulse.
- Parameters SCLK_DIV=1, DWELL_CYCLES=1 → row period is 67 cycles, ser_clk toggles every cycle during SHIFT, and row_en is high for exactly 1 cycle per row.
